// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-N_OUT stream demultiplexer with broadcast.
// Holds one beat: a pending mask records which channels still owe a
// handshake, and out_data stays stable until every pending channel completes.
// The next beat is accepted in the same cycle the last channel completes,
// so back-to-back beats stream without a bubble.
// Optional feature macro: DMUX_STREAM_CNT_EN adds one 16-bit completion
// counter per channel, read through cnt_idx/cnt_val.
module dmux_stream #(
  parameter int WIDTH = 16,
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_bcast,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_sel
`ifdef DMUX_STREAM_CNT_EN
  ,
  input  logic [SEL_W-1:0] cnt_idx,
  output logic [15:0]      cnt_val
`endif
);

  // Channel count widened by one bit so the range check never truncates.
  localparam logic [SEL_W:0] N_OUT_EXT = (SEL_W + 1)'(N_OUT);

  logic [N_OUT-1:0] pending_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;

  logic [N_OUT-1:0] completing;
  logic [N_OUT-1:0] remaining;
  logic             beat_done;
  logic             accept;
  logic             sel_in_range;
  logic [N_OUT-1:0] sel_onehot;
  logic [N_OUT-1:0] pending_d;
  logic             err_d;

  // Handshake bookkeeping: ready bits of idle channels are masked off.
  always_comb begin
    completing   = pending_q & out_ready;
    remaining    = pending_q & ~out_ready;
    beat_done    = (pending_q != '0) && (remaining == '0);
    in_ready     = (pending_q == '0) || beat_done;
    accept       = in_valid && in_ready;
    sel_in_range = ({1'b0, in_sel} < N_OUT_EXT);
  end

  // Decode the destination index into a one-hot channel mask.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sel_onehot[i] = (in_sel == SEL_W'(i));
    end
  end

  // Next pending mask: a new beat replaces the old mask outright, so the
  // clears of the channels completing on this edge cannot mask it.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    pending_d = remaining;
    err_d     = 1'b0;
    if (accept) begin
      if (in_bcast) begin
        pending_d = '1;
      end else if (sel_in_range) begin
        pending_d = sel_onehot;
      end else begin
        pending_d = '0;
        err_d     = 1'b1;
      end
    end
  end

  // Beat state registers; the payload is captured on every accept,
  // including dropped out-of-range beats, and is never cleared when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      pending_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
      if (accept) begin
        data_q <= in_data;
      end
    end
  end

  assign out_valid = pending_q;
  assign out_data  = data_q;
  assign err_sel   = err_q;

`ifdef DMUX_STREAM_CNT_EN
  logic [15:0] cnt_q [N_OUT];

  // Per-channel completion counters; a broadcast beat bumps each channel
  // once, in whichever cycle that channel completes. Wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the counter array is a bank of flops that must read zero after
    // reset, so it is reset element by element rather than left as memory.
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (completing[i]) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Counter readout; indices past the last channel read as zero.
  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (cnt_idx == SEL_W'(i)) begin
        cnt_val = cnt_q[i];
      end
    end
  end
`endif

  // Once raised, a pending bit may only fall through its own handshake.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (pending_q[i] && !out_ready[i] && !accept) begin
          assert (pending_d[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: table-driven bench for dmux_stream (8 channels) plus a
// 5-channel instance for out-of-range select handling.
module tb_dmux_stream;

  logic clk;
  logic rst_n;

  // 8-channel instance
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        in_bcast;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [15:0] out_data;
  logic        err_sel;

  // 5-channel instance
  logic        v5_in_valid;
  logic        v5_in_ready;
  logic [15:0] v5_in_data;
  logic [2:0]  v5_in_sel;
  logic        v5_in_bcast;
  logic [4:0]  v5_out_valid;
  logic [4:0]  v5_out_ready;
  logic [15:0] v5_out_data;
  logic        v5_err_sel;

`ifdef DMUX_STREAM_CNT_EN
  logic [2:0]  cnt_idx;
  logic [15:0] cnt_val;
  logic [2:0]  v5_cnt_idx;
  logic [15:0] v5_cnt_val;
`endif

  int total_checks;
  int passed_checks;

  dmux_stream #(.WIDTH(16), .N_OUT(8), .SEL_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_sel   (err_sel)
`ifdef DMUX_STREAM_CNT_EN
    ,
    .cnt_idx   (cnt_idx),
    .cnt_val   (cnt_val)
`endif
  );

  dmux_stream #(.WIDTH(16), .N_OUT(5), .SEL_W(3)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v5_in_valid),
    .in_ready  (v5_in_ready),
    .in_data   (v5_in_data),
    .in_sel    (v5_in_sel),
    .in_bcast  (v5_in_bcast),
    .out_valid (v5_out_valid),
    .out_ready (v5_out_ready),
    .out_data  (v5_out_data),
    .err_sel   (v5_err_sel)
`ifdef DMUX_STREAM_CNT_EN
    ,
    .cnt_idx   (v5_cnt_idx),
    .cnt_val   (v5_cnt_val)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic [2:0]  sel;
    logic        bc;
    logic [7:0]  rdy;
    logic        e_ir;   // in_ready before the edge
    logic [7:0]  e_ov;   // out_valid after the edge
    logic [15:0] e_d;    // out_data after the edge
    logic        e_err;  // err_sel after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] s,
                       input logic b, input logic [7:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_bcast  = b;
    out_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'hFF);
    v5_in_valid  = 1'b0;
    v5_in_data   = 16'h0;
    v5_in_sel    = 3'd0;
    v5_in_bcast  = 1'b0;
    v5_out_ready = 5'h1F;
`ifdef DMUX_STREAM_CNT_EN
    cnt_idx    = 3'd0;
    v5_cnt_idx = 3'd0;
`endif

    // Vector table: {vld, data, sel, bc, rdy, e_ir, e_ov, e_d, e_err}
    vecs.push_back('{1'b1, 16'h1234, 3'd5, 1'b0, 8'hFF, 1'b1, 8'h20, 16'h1234, 1'b0});
    for (int k = 0; k < 8; k++) begin
      vecs.push_back('{1'b1, 16'hA000 + 16'(k), 3'(k), 1'b0, 8'hFF,
                       1'b1, 8'(1 << k), 16'hA000 + 16'(k), 1'b0});
    end
    vecs.push_back('{1'b0, 16'h0000, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h00, 16'hA007, 1'b0});
    // broadcast split across two cycles, with a follow-up beat held while stalled
    vecs.push_back('{1'b1, 16'hBEEF, 3'd6, 1'b1, 8'h0F, 1'b1, 8'hFF, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b1, 16'h5555, 3'd3, 1'b0, 8'h0F, 1'b0, 8'hF0, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b1, 16'h5555, 3'd3, 1'b0, 8'hF0, 1'b1, 8'h08, 16'h5555, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 3'd0, 1'b0, 8'hF7, 1'b0, 8'h08, 16'h5555, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 3'd0, 1'b0, 8'h08, 1'b1, 8'h00, 16'h5555, 1'b0});
    // idle ignores ready bits; broadcast with everyone ready drains in one cycle
    vecs.push_back('{1'b0, 16'h0000, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h5555, 1'b0});
    vecs.push_back('{1'b1, 16'h0F0F, 3'd2, 1'b1, 8'hFF, 1'b1, 8'hFF, 16'h0F0F, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h00, 16'h0F0F, 1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset in_ready",  32'(in_ready),  32'h1);
    check("reset out_data",  32'(out_data),  32'h0);
    check("reset err_sel",   32'(err_sel),   32'h0);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].data, vecs[i].sel, vecs[i].bc, vecs[i].rdy);
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].e_d));
      check($sformatf("v%0d err_sel", i),   32'(err_sel),   32'(vecs[i].e_err));
    end

    // Out-of-range select on the 5-channel instance: sel 6 and sel 5
    for (int s = 6; s >= 5; s--) begin
      @(negedge clk);
      v5_in_valid = 1'b1;
      v5_in_data  = 16'hE000 + 16'(s);
      v5_in_sel   = 3'(s);
      #1;
      check($sformatf("n5 sel%0d in_ready", s), 32'(v5_in_ready), 32'h1);
      @(posedge clk);
      #1;
      check($sformatf("n5 sel%0d err_sel", s),   32'(v5_err_sel),   32'h1);
      check($sformatf("n5 sel%0d out_valid", s), 32'(v5_out_valid), 32'h0);
    end
    @(negedge clk);
    v5_in_sel  = 3'd4;
    v5_in_data = 16'h4444;
    #1;
    check("n5 sel4 in_ready", 32'(v5_in_ready), 32'h1);
    @(posedge clk);
    #1;
    check("n5 sel4 err_sel",   32'(v5_err_sel),   32'h0);
    check("n5 sel4 out_valid", 32'(v5_out_valid), 32'h10);
    check("n5 sel4 out_data",  32'(v5_out_data),  32'h4444);
    @(negedge clk);
    v5_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("n5 drain out_valid", 32'(v5_out_valid), 32'h0);

    // Reset in the middle of a stalled broadcast
    @(negedge clk);
    drive(1'b1, 16'hCAFE, 3'd0, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    check("midrst pending", 32'(out_valid), 32'hFF);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst async out_valid", 32'(out_valid), 32'h0);
    check("midrst async out_data",  32'(out_data),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("postrst out_valid", 32'(out_valid), 32'h0);
    end
    check("postrst in_ready", 32'(in_ready), 32'h1);

`ifdef DMUX_STREAM_CNT_EN
    // Three beats to channel 2, then one broadcast
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 16'(k), 3'd2, (k == 3), 8'hFF);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'hFF);
    @(negedge clk);
    cnt_idx = 3'd2;
    #1;
    check("cnt ch2", 32'(cnt_val), 32'd4);
    cnt_idx = 3'd0;
    #1;
    check("cnt ch0", 32'(cnt_val), 32'd1);
    v5_cnt_idx = 3'd6;
    #1;
    check("cnt n5 idx6", 32'(v5_cnt_val), 32'd0);

    // 65536 beats to channel 1 wrap its counter to zero
    do_reset();
    cnt_idx = 3'd1;
    @(negedge clk);
    drive(1'b1, 16'h1111, 3'd1, 1'b0, 8'hFF);
    repeat (65536) @(posedge clk);
    #1;
    check("cnt ch1 before wrap", 32'(cnt_val), 32'hFFFF);
    @(negedge clk);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 8'hFF);
    @(posedge clk);
    #1;
    check("cnt ch1 wrapped", 32'(cnt_val), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
